// File: rtl/dram_pkg.sv
// Shared types, default timing and address-slicing helpers for the DRAM controller model.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACT,
    REF
  } state_t;

  localparam int DEF_MEM_AW = 14;
  localparam int DEF_COL_W  = 8;
  localparam int DEF_T_RP   = 2;
  localparam int DEF_T_RCD  = 2;
  localparam int DEF_T_RFC  = 8;
  localparam int DEF_T_REFI = 1024;
  localparam int TMR_W      = 16;

  // Row field of a byte address; bits above the storage size alias.
  function automatic logic [31:0] row_of(input logic [31:0] addr, input int mem_aw,
                                         input int col_w);
    logic [31:0] mask;
    mask = (32'd1 << (mem_aw - col_w)) - 32'd1;
    return (addr >> (col_w + 2)) & mask;
  endfunction

  function automatic logic [31:0] col_of(input logic [31:0] addr, input int col_w);
    logic [31:0] mask;
    mask = (32'd1 << col_w) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter; done pulses in the last cycle of a loaded interval.
module dram_timer
  import dram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign done = (cnt == TMR_W'(1));

endmodule

// File: rtl/dram_ctrl.sv
// Single-bank DRAM controller/model with open-row buffer and backing storage.
// Define DRAM_REFRESH_EN to include the periodic refresh counter and REF state.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int COL_W  = DEF_COL_W,
  parameter int T_RP   = DEF_T_RP,
  parameter int T_RCD  = DEF_T_RCD,
  parameter int T_RFC  = DEF_T_RFC,
  parameter int T_REFI = DEF_T_REFI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_cs,
  input  logic        dram_we,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_din,
  output logic [31:0] dram_dout,
  output logic        dram_nwait
);

  localparam int ROW_W = MEM_AW - COL_W;
  // Cycles spent in ACT/REF; the request cycle itself is the first stall cycle.
  localparam logic [TMR_W-1:0] ACT_CLOSED = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] ACT_OPEN   = TMR_W'(T_RP + T_RCD - 1);
  localparam logic [TMR_W-1:0] REF_LEN    = TMR_W'(T_RFC - 1);

  if (T_RCD < 1 || T_RFC < 1 || T_RP < 0 || T_REFI <= T_RFC + T_RP + T_RCD) begin : g_bad_params
    $error("dram_ctrl: invalid timing parameters");
  end

  state_t            state, state_n;
  logic              row_open;
  logic [ROW_W-1:0]  open_row, act_row, req_row;
  logic [COL_W-1:0]  req_col;
  logic [MEM_AW-1:0] mem_idx;
  logic              row_miss, accept, ref_pending;
  logic              tmr_start, tmr_done, open_set, row_close, ref_clear;
  logic [TMR_W-1:0]  tmr_load, act_len;
  logic [31:0]       mem [2**MEM_AW];

  assign req_row  = ROW_W'(row_of(dram_addr, MEM_AW, COL_W));
  assign req_col  = COL_W'(col_of(dram_addr, COL_W));
  assign mem_idx  = {req_row, req_col};
  assign row_miss = !(row_open && (open_row == req_row));
  assign act_len  = row_open ? ACT_OPEN : ACT_CLOSED;

  assign dram_nwait = (state == IDLE) && !ref_pending && !(dram_cs && row_miss);
  assign accept     = dram_cs && dram_nwait && !rst;

`ifdef DRAM_REFRESH_EN
  localparam int REFI_W = $clog2(T_REFI);
  logic [REFI_W-1:0] ref_cnt;

  // Pending becomes visible in the cycle the counter shows T_REFI-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      ref_cnt     <= (ref_cnt == REFI_W'(T_REFI - 1)) ? '0 : ref_cnt + REFI_W'(1);
      ref_pending <= (ref_pending && !ref_clear) || (ref_cnt == REFI_W'(T_REFI - 2));
    end
  end
`else
  assign ref_pending = 1'b0;
`endif

  dram_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_n   = state;
    tmr_start = 1'b0;
    tmr_load  = '0;
    open_set  = 1'b0;
    row_close = 1'b0;
    ref_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_pending) begin
          ref_clear = 1'b1;
          row_close = 1'b1;
          if (REF_LEN != '0) begin
            state_n   = REF;
            tmr_start = 1'b1;
            tmr_load  = REF_LEN;
          end
        end else if (dram_cs && row_miss) begin
          if (act_len == '0) begin
            open_set = 1'b1;
          end else begin
            state_n   = ACT;
            tmr_start = 1'b1;
            tmr_load  = act_len;
          end
        end
      end
      ACT: begin
        if (tmr_done) begin
          state_n  = IDLE;
          open_set = 1'b1;
        end
      end
      REF: begin
        if (tmr_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // act_row remembers the requested row so activation completes even if cs drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_open <= 1'b0;
      open_row <= '0;
      act_row  <= '0;
    end else begin
      state <= state_n;
      if (tmr_start) act_row <= req_row;
      if (open_set) begin
        row_open <= 1'b1;
        open_row <= (state == ACT) ? act_row : req_row;
      end else if (row_close) begin
        row_open <= 1'b0;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (accept && dram_we) mem[mem_idx] <= dram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dram_dout <= '0;
    end else if (accept && !dram_we) begin
      dram_dout <= mem[mem_idx];
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Scoreboard bench for dram_ctrl: driver queues expected wait counts/read data, monitor checks.
module tb_dram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, we;
  logic [31:0] addr, din, dout;
  logic        nwait;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          waits;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Cycles since the last reset edge; tracks the refresh interval.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  dram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .dram_cs    (cs),
    .dram_we    (we),
    .dram_addr  (addr),
    .dram_din   (din),
    .dram_dout  (dout),
    .dram_nwait (nwait)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called at posedge+1; leaves cs asserted, returns at posedge+1 after the accept edge.
  task automatic req(input string name, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_data, input int exp_waits);
    exp_t e;
    e.we = w; e.data = exp_data; e.waits = exp_waits; e.name = name;
    sb.push_back(e);
    cs = 1'b1; we = w; addr = a; din = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (nwait) break;
      if (n >= 64) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: nwait stayed low for %0d cycles, expected %0d", name, n + 1, exp_waits);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    cs = 1'b0; we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: counts stall cycles, checks them on accept, checks read data one cycle later.
  initial begin : monitor
    int          waits;
    bit          rd_due;
    exp_t        cur;
    logic [31:0] last_rd;
    waits = 0; rd_due = 0; last_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        waits = 0; rd_due = 0; last_rd = '0;
        continue;
      end
      if (rd_due) begin
        check({cur.name, "_rdata"}, dout, cur.data);
        last_rd = cur.data;
        rd_due  = 0;
      end
      if (cs) begin
        if (!nwait) begin
          check("stall_dout", dout, last_rd);
          waits++;
        end else begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: accepted addr %h with empty scoreboard", addr);
          end else begin
            cur = sb.pop_front();
            check({cur.name, "_waits"}, waits, cur.waits);
            if (!cur.we) rd_due = 1;
          end
          waits = 0;
        end
      end else begin
        waits = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cs = 1'b0; we = 1'b0; addr = '0; din = '0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_nwait", nwait, 1);
    check("rst_dout", dout, 0);
    @(posedge clk); #1;

    // 1: store a known word, reset (row closes, storage kept), read it with a T_RCD miss
    req("t1_wr", 1, 32'h100, 32'h1111_0000, 0, 2);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_rst_dout", dout, 0);
    @(posedge clk); #1;
    req("t1_rd", 0, 32'h100, 0, 32'h1111_0000, 2);

    // 2: row-hit writes and reads of one line, no stalls
    for (int k = 0; k < 4; k++)
      req("t2_wr", 1, 32'h110 + 32'(4 * k), 32'hA0A0_0000 | 32'(k), 0, 0);
    for (int k = 0; k < 4; k++)
      req("t2_rd", 0, 32'h110 + 32'(4 * k), 0, 32'hA0A0_0000 | 32'(k), 0);
    idle(1);

    // 3: row 0 open, row 1 access pays T_RP+T_RCD; aliased address hits the same word
    req("t3_wr", 1, 32'h400, 32'hB0B0_4000, 0, 4);
    req("t3_rd", 0, 32'h400, 0, 32'hB0B0_4000, 0);
    req("t3_alias", 0, 32'h0001_0400, 0, 32'hB0B0_4000, 0);
    idle(1);

    // 4: line write then cache-style fill; last beat checked in the idle cycle
    for (int k = 0; k < 4; k++)
      req("t4_wr", 1, 32'h200 + 32'(4 * k), 32'hC0C0_0000 | 32'(k), 0, (k == 0) ? 4 : 0);
    idle(1);
    for (int k = 0; k < 4; k++)
      req("t4_fill", 0, 32'h200 + 32'(4 * k), 0, 32'hC0C0_0000 | 32'(k), 0);
    idle(1);
    @(negedge clk);
    check("t4_hold", dout, 32'hC0C0_0003);
    @(posedge clk); #1;
    req("t4_wr_new", 1, 32'h204, 32'hDEAD_0204, 0, 0);
    req("t4_rd_new", 0, 32'h204, 0, 32'hDEAD_0204, 0);
    idle(1);

    // 6: reset during ACT aborts the access; the same row must pay T_RCD again
    cs = 1'b1; we = 1'b1; addr = 32'h800; din = 32'hD0D0_0800;
    @(negedge clk);
    check("t6_miss_nwait", nwait, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_act_nwait", nwait, 0);
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_nwait", nwait, 1);
    check("t6_dout", dout, 0);
    @(posedge clk); #1;
    req("t6_wr", 1, 32'h800, 32'hD0D0_0800, 0, 2);
    req("t6_rd", 0, 32'h204, 0, 32'hDEAD_0204, 4);
    idle(1);

`ifdef DRAM_REFRESH_EN
    // 5: request in the cycle the refresh counter shows T_REFI-1: T_RFC + T_RCD stall
    for (int n = 0; n < 3000 && cyc != 1023; n++) begin
      @(posedge clk); #1;
    end
    check("t5_align", cyc, 1023);
    req("t5_rd", 0, 32'h800, 0, 32'hD0D0_0800, 10);
    idle(2);
`endif

    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d requests never accepted, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
